// File: rtl/sfa_pkg.sv
// rtl/sfa_pkg.sv - shared types, FUNCTW tables and constants for scale_factor_adapt
package sfa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UPD_U,
      ST_UPD_L,
      ST_MIX,
      ST_DONE
   } sfa_state_e;

   typedef enum logic [1:0] {
      RATE_16K = 2'b00,
      RATE_24K = 2'b01,
      RATE_32K = 2'b10,
      RATE_40K = 2'b11
   } sfa_rate_e;

   localparam logic [12:0] YU_MIN = 13'd544;
   localparam logic [12:0] YU_MAX = 13'd5120;
   localparam logic [12:0] YU_RST = 13'd544;
   localparam logic [12:0] Y_RST  = 13'd544;
   localparam logic [18:0] YL_RST = 19'd34816;
   localparam logic [6:0]  AL_MAX = 7'd64;

   localparam logic signed [11:0] FUNCTW_16K [0:1] = '{-12'sd22, 12'sd439};
   localparam logic signed [11:0] FUNCTW_24K [0:3] = '{-12'sd4, 12'sd30, 12'sd137, 12'sd582};
   localparam logic signed [11:0] FUNCTW_32K [0:7] = '{
      -12'sd12, 12'sd18, 12'sd41, 12'sd64, 12'sd112, 12'sd198, 12'sd355, 12'sd1122};
   localparam logic signed [11:0] FUNCTW_40K [0:15] = '{
      12'sd14, 12'sd14, 12'sd24, 12'sd39, 12'sd40, 12'sd41, 12'sd58, 12'sd100,
      12'sd141, 12'sd179, 12'sd219, 12'sd280, 12'sd358, 12'sd440, 12'sd529, 12'sd696};

   // Codes with the sign bit set are folded by one's complement before lookup.
   function automatic logic signed [11:0] functw(input logic [1:0] rate, input logic [4:0] code);
      logic             sign;
      logic [4:0]       fold;
      logic signed [11:0] w;
      case (rate)
         RATE_16K: sign = code[1];
         RATE_24K: sign = code[2];
         RATE_32K: sign = code[3];
         default:  sign = code[4];
      endcase
      fold = sign ? ~code : code;
      case (rate)
         RATE_16K: w = FUNCTW_16K[fold[0]];
         RATE_24K: w = FUNCTW_24K[fold[1:0]];
         RATE_32K: w = FUNCTW_32K[fold[2:0]];
         default:  w = FUNCTW_40K[fold[3:0]];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sfa_mul7.sv
// rtl/sfa_mul7.sv - 14-bit x 7-bit shift-add multiplier, one multiplier bit per cycle
module sfa_mul7
   import sfa_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] a,
   input  logic [6:0]  b,
   output logic        done,
   output logic [20:0] p
);

   logic [20:0] acc_q, acc_d;
   logic [20:0] mcand_q, mcand_d;
   logic [5:0]  mplier_q, mplier_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        done_q, done_d;

   // The start edge already folds in bit 0, so six more edges finish the product.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      if (start) begin
         acc_d    = b[0] ? {7'b0, a} : 21'd0;
         mcand_d  = {6'b0, a, 1'b0};
         mplier_d = b[6:1];
         cnt_d    = 3'd6;
      end else if (cnt_q != 3'd0) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = {mcand_q[19:0], 1'b0};
         mplier_d = {1'b0, mplier_q[5:1]};
         cnt_d    = cnt_q - 3'd1;
         done_d   = (cnt_q == 3'd1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

   assign done = done_q;
   assign p    = acc_q;

endmodule

// File: rtl/scale_factor_adapt.sv
// rtl/scale_factor_adapt.sv - ADPCM quantizer scale factor adaptation (fast/slow mix)
// Optional SFA_OVERRUN_EN: sticky ovr when in_valid arrives while busy.
module scale_factor_adapt
   import sfa_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        scan_in0,
   input  logic        scan_en,
   output logic        scan_out0,
   input  logic [4:0]  I,
   input  logic [1:0]  RATE,
   input  logic [6:0]  AL,
   input  logic        in_valid,
   output logic [12:0] Y,
   output logic [18:0] YL,
   output logic        y_valid,
   output logic        busy,
   output logic        ovr
);

   sfa_state_e  state_q, state_d;
   logic [4:0]  i_q, i_d;
   logic [1:0]  rate_q, rate_d;
   logic [6:0]  al_q, al_d;
   logic [12:0] yu_q, yu_d;
   logic [18:0] yl_q, yl_d;
   logic [12:0] y_q, y_d;
   logic        y_valid_q, y_valid_d;
   logic        busy_q, busy_d;
   logic        ovr_q, ovr_d;
   logic        d_neg_q, d_neg_d;

   logic signed [11:0] wi;
   logic [16:0] dif_u;
   logic [12:0] yut, yu_lim;
   logic [19:0] dif_l;
   logic [18:0] yl_next;
   logic [13:0] d_val, d_mag;
   logic [12:0] prodm, prod, y_next;
   logic        mul_start, mul_done;
   logic [20:0] mul_p;
   logic        unused_sigs;

   assign wi      = functw(rate_q, i_q);
   assign dif_u   = {wi, 5'b0} - {4'b0, y_q};
   assign yut     = y_q + {dif_u[16], dif_u[16:5]};
   assign yu_lim  = (yut < YU_MIN) ? YU_MIN : ((yut > YU_MAX) ? YU_MAX : yut);
   assign dif_l   = {1'b0, yu_q, 6'b0} - {1'b0, yl_q};
   assign yl_next = yl_q + {{5{dif_l[19]}}, dif_l[19:6]};
   // D is formed from the YL being loaded so the multiply can start on entry to MIX.
   assign d_val   = {1'b0, yu_q} - {1'b0, yl_next[18:6]};
   assign d_mag   = d_val[13] ? (~d_val + 14'd1) : d_val;
   assign prodm   = mul_p[18:6];
   assign prod    = d_neg_q ? (~prodm + 13'd1) : prodm;
   assign y_next  = yl_q[18:6] + prod;

   sfa_mul7 u_mul (
      .clk   (clk),
      .rst   (reset),
      .start (mul_start),
      .a     (d_mag),
      .b     (al_q),
      .done  (mul_done),
      .p     (mul_p)
   );

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      rate_d    = rate_q;
      al_d      = al_q;
      yu_d      = yu_q;
      yl_d      = yl_q;
      y_d       = y_q;
      y_valid_d = 1'b0;
      busy_d    = busy_q;
      d_neg_d   = d_neg_q;
      mul_start = 1'b0;
`ifdef SFA_OVERRUN_EN
      ovr_d     = ovr_q | (in_valid & busy_q);
`else
      ovr_d     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && !busy_q) begin
               i_d     = I;
               rate_d  = RATE;
               al_d    = (AL > AL_MAX) ? AL_MAX : AL;
               busy_d  = 1'b1;
               state_d = ST_UPD_U;
            end
         end
         ST_UPD_U: begin
            yu_d    = yu_lim;
            state_d = ST_UPD_L;
         end
         ST_UPD_L: begin
            yl_d      = yl_next;
            d_neg_d   = d_val[13];
            mul_start = 1'b1;
            state_d   = ST_MIX;
         end
         ST_MIX: begin
            if (mul_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            y_d       = y_next;
            y_valid_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         i_q       <= '0;
         rate_q    <= '0;
         al_q      <= '0;
         yu_q      <= YU_RST;
         yl_q      <= YL_RST;
         y_q       <= Y_RST;
         y_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
         d_neg_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         rate_q    <= rate_d;
         al_q      <= al_d;
         yu_q      <= yu_d;
         yl_q      <= yl_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         busy_q    <= busy_d;
         ovr_q     <= ovr_d;
         d_neg_q   <= d_neg_d;
      end
   end

   assign Y           = y_q;
   assign YL          = yl_q;
   assign y_valid     = y_valid_q;
   assign busy        = busy_q;
   assign ovr         = ovr_q;
   assign scan_out0   = 1'b0;
   assign unused_sigs = ^{scan_in0, scan_en, mul_p[20:19], mul_p[5:0]};

endmodule

// File: tb/tb_scale_factor_adapt.sv
// tb/tb_scale_factor_adapt.sv - scoreboard bench for scale_factor_adapt
module tb_scale_factor_adapt;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scan_in0 = 1'b0;
   logic        scan_en = 1'b0;
   logic        scan_out0;
   logic [4:0]  I = '0;
   logic [1:0]  RATE = '0;
   logic [6:0]  AL = '0;
   logic        in_valid = 1'b0;
   logic [12:0] Y;
   logic [18:0] YL;
   logic        y_valid;
   logic        busy;
   logic        ovr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int y;
      int yl;
      int t0;
   } exp_t;

   exp_t sb_q[$];

   scale_factor_adapt dut (
      .clk       (clk),
      .reset     (reset),
      .scan_in0  (scan_in0),
      .scan_en   (scan_en),
      .scan_out0 (scan_out0),
      .I         (I),
      .RATE      (RATE),
      .AL        (AL),
      .in_valid  (in_valid),
      .Y         (Y),
      .YL        (YL),
      .y_valid   (y_valid),
      .busy      (busy),
      .ovr       (ovr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (y_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_y_valid", y_valid, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("y", Y, e.y);
            if (e.yl >= 0) check("yl", YL, e.yl);
            check("latency", cyc - e.t0, 10);
            check("y_le_5120", (Y <= 13'd5120) ? 1 : 0, 1);
         end
      end
   end

   task automatic issue(input logic [1:0] r, input logic [4:0] code, input logic [6:0] al,
                        input int ey, input int eyl, output int t0);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("issue_timeout", busy, 0);
      RATE = r;
      I = code;
      AL = al;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e.y = ey;
      e.yl = eyl;
      e.t0 = cyc;
      t0 = cyc;
      sb_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy) && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", sb_q.size(), 0);
   endtask

   // in_valid is held high while reset is asserted; it must not start an update.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b1;
      I = 5'd7;
      RATE = 2'b10;
      AL = 7'd64;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      @(negedge clk);
   endtask

   int t0, t_prev, ey;

   initial begin
      do_reset();
      check("rst_y", Y, 544);
      check("rst_yl", YL, 34816);
      check("rst_busy", busy, 0);
      check("rst_y_valid", y_valid, 0);
      check("rst_ovr", ovr, 0);
      check("scan_out0", scan_out0, 0);

      issue(2'b10, 5'd0, 7'd0, 544, 34816, t0);
      wait_idle();

      do_reset();
      issue(2'b10, 5'd7, 7'd64, 1649, 35921, t0);
      wait_idle();

      do_reset();
      issue(2'b10, 5'd7, 7'd0, 561, 35921, t_prev);
      issue(2'b10, 5'd0, 7'd25, 554, 35903, t0);
      check("back_to_back", t0 - t_prev, 11);
      wait_idle();

      do_reset();
      issue(2'b00, 5'd1, 7'd32, 758, 35238, t0);
      wait_idle();

      do_reset();
      issue(2'b11, 5'd15, 7'd100, 1223, 35495, t0);
      wait_idle();

      do_reset();
      issue(2'b01, 5'd4, 7'd0, 552, 35381, t0);
      wait_idle();

      do_reset();
      issue(2'b10, 5'd7, 7'd64, 1649, 35921, t0);
      repeat (3) @(negedge clk);
      I = 5'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_idle();
      repeat (15) @(negedge clk);
`ifdef SFA_OVERRUN_EN
      check("ovr_set", ovr, 1);
`else
      check("ovr_tied", ovr, 0);
`endif

      do_reset();
      issue(2'b10, 5'd7, 7'd64, 1649, 35921, t0);
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      sb_q.delete();
      check("abort_y", Y, 544);
      check("abort_yl", YL, 34816);
      check("abort_busy", busy, 0);
      check("abort_y_valid", y_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      check("post_abort_y", Y, 544);
      check("post_abort_yl", YL, 34816);
      check("post_abort_busy", busy, 0);
      issue(2'b10, 5'd7, 7'd64, 1649, 35921, t0);
      wait_idle();

      do_reset();
      t_prev = 0;
      for (int k = 0; k < 200; k++) begin
         case (k)
            0:       ey = 1649;
            1:       ey = 2719;
            2:       ey = 3756;
            3:       ey = 4760;
            default: ey = 5120;
         endcase
         issue(2'b10, 5'd7, 7'd64, ey, (k == 0) ? 35921 : -1, t0);
         if (k > 0) check("throughput", t0 - t_prev, 11);
         t_prev = t0;
      end
      wait_idle();
      check("sat_y", Y, 5120);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scale_factor_adapt.md
SCALE_FACTOR_ADAPT -- requirements
Module: scale_factor_adapt

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports scan_in0 (input, 1), scan_en (input, 1) and scan_out0 (output, 1), the DFT scan chain; scan_out0 is driven 0 in functional RTL.
REQ-004 SHALL have port I, input, 5, the ADPCM codeword for the current sample; LSB-aligned, sign = MSB of the RATE-selected width.
REQ-005 SHALL have port RATE, input, 2, with 00=16k (2-bit I), 01=24k (3-bit), 10=32k (4-bit), 11=40k (5-bit).
REQ-006 SHALL have port AL, input, 7, the unsigned speed-control mix factor (0..64).
REQ-007 SHALL have port in_valid, input, 1, a one-cycle strobe qualifying I, RATE and AL.
REQ-008 SHALL have port Y, output, 13, the unsigned scale factor consumed by the inverse adaptive quantizer.
REQ-009 SHALL have port YL, output, 19, the slow scale factor state.
REQ-010 SHALL have port y_valid, output, 1, a one-cycle pulse marking an updated Y.
REQ-011 SHALL have port busy, output, 1, high while an update is in progress.
REQ-012 SHALL have port ovr, output, 1, a sticky overrun flag (see REQ-026).

Function
REQ-013 SHALL accept a sample when in_valid=1 and busy=0, and register I, RATE and AL (AL>64 saturated to 64).
REQ-014 SHALL sequence states IDLE -> UPD_U -> UPD_L -> MIX (7 cycles) -> DONE -> IDLE, one state per cycle.
REQ-015 SHALL, in UPD_U, fold I to a magnitude index (one's complement if sign set) and look up the 12-bit two's-complement WI from the RATE-selected G.726 FUNCTW table.
REQ-016 SHALL compute in UPD_U: DIF = (WI<<5) - Y mod 2^17; YUT = Y + (DIF>>>5) mod 2^13; YU = clamp(YUT, 544, 5120), registered.
REQ-017 SHALL compute in UPD_L: DIF = (YU<<6) - YL mod 2^20; YL <= YL + (DIF>>>6) mod 2^19.
REQ-018 SHALL compute in MIX: D = YU - (YL>>6), a 14-bit two's-complement value; PRODM = (|D| * AL) >> 6 by a 7-step shift-add multiply; PROD = sign(D) ? -PRODM : PRODM.
REQ-019 SHALL, in DONE, load Y <= ((YL>>6) + PROD) mod 2^13, assert y_valid for exactly this cycle, and drop busy on the next edge.
REQ-020 SHALL assert y_valid 10 rising edges after the accepting edge; busy is high from the edge after acceptance through DONE.
REQ-021 SHALL hold Y and YL constant except at the DONE and UPD_L loads respectively.
REQ-022 SHALL accept a new sample in the cycle after DONE (back-to-back throughput of one sample per 11 cycles).

Reset
REQ-023 SHALL, on reset assertion and independent of clk, force state=IDLE, YU=544, YL=34816, Y=544, y_valid=0, busy=0, ovr=0, multiplier registers=0.
REQ-024 SHALL abort any in-flight update on reset mid-operation, with no partial YL or Y commit after release.
REQ-025 SHALL ignore in_valid during the cycle in which reset is high.

Configuration
REQ-026 SHALL, with SFA_OVERRUN_EN defined, set ovr sticky (cleared only by reset) when in_valid=1 while busy=1; the sample is dropped either way.
REQ-027 SHALL, without SFA_OVERRUN_EN, tie ovr to 0 and keep the port list unchanged.

Structure
REQ-028 SHALL place the four FUNCTW tables, the RATE encodings, the YU limits (544/5120), the reset constants (544/34816) and the FSM state typedef in a shared package sfa_pkg.
REQ-029 SHALL implement the shift-add multiplier as sub-module sfa_mul7 (14-bit magnitude x 7-bit, 7 cycles, start/done).

Verification
REQ-030 SHALL check, after reset: Y=544, YL=34816, busy=0, y_valid=0, ovr=0.
REQ-031 SHALL check, from reset, RATE=10, I=0 (WI=-12), AL=0 -> YU clamps to 544, YL=34816, Y=544, y_valid at edge 10.
REQ-032 SHALL check, from reset, RATE=10, I=7 (WI=1122), AL=64 -> YU=1649, YL=35921, Y=1649; the same with AL=0 -> Y=561.
REQ-033 SHALL check 200 repeats of RATE=10, I=7, AL=64 -> YU saturates at 5120, Y never exceeds 5120.
REQ-034 SHALL check in_valid pulsed during busy -> sample ignored, Y result unchanged, ovr=1 only with SFA_OVERRUN_EN.
REQ-035 SHALL check reset asserted in the MIX state -> immediate return to the REQ-023 values, no y_valid pulse.
